// File: rtl/lcm_pkg.sv
// Shared types for layer_color_mapper: fade states, RGB bundle, brightness limit.
package lcm_pkg;

    typedef enum logic [1:0] {
        ON,
        FADING_OUT,
        OFF,
        FADING_IN
    } fade_state_t;

    localparam int LCM_COLOR_W = 8;

    typedef struct packed {
        logic [LCM_COLOR_W-1:0] R;
        logic [LCM_COLOR_W-1:0] G;
        logic [LCM_COLOR_W-1:0] B;
    } rgb_t;

    localparam logic [7:0] BRIGHT_MAX = 8'hFF;

endpackage

// File: rtl/lcm_fade_ctrl.sv
// Frame-synchronous fade FSM holding the global brightness level.
module lcm_fade_ctrl
    import lcm_pkg::*;
#(
    parameter int FADE_STEP = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_start,
    input  logic       fade_out_req,
    input  logic       fade_in_req,
    output logic [7:0] brightness,
    output logic       fade_busy
);

    localparam logic [7:0] STEP8 = 8'(FADE_STEP);

    fade_state_t state_q, state_d, mode;
    logic [7:0]  bright_q, bright_d;
    logic        req_out, req_in;

    assign req_out = fade_out_req & ~fade_in_req;
    assign req_in  = fade_in_req & ~fade_out_req;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ON;
            bright_q <= BRIGHT_MAX;
        end else begin
            state_q  <= state_d;
            bright_q <= bright_d;
        end
    end

    always_comb begin
        mode     = state_q;
        state_d  = state_q;
        bright_d = bright_q;
        unique case (state_q)
            ON:         if (req_out) mode = FADING_OUT;
            FADING_OUT: if (req_in)  mode = FADING_IN;
            OFF:        if (req_in)  mode = FADING_IN;
            FADING_IN:  if (req_out) mode = FADING_OUT;
        endcase
        state_d = mode;
        // The step follows the direction chosen in this same cycle
        if (frame_start) begin
            if (mode == FADING_OUT) begin
                if (bright_q <= STEP8) begin
                    bright_d = 8'h00;
                    state_d  = OFF;
                end else begin
                    bright_d = bright_q - STEP8;
                end
            end else if (mode == FADING_IN) begin
                if (bright_q >= BRIGHT_MAX - STEP8) begin
                    bright_d = BRIGHT_MAX;
                    state_d  = ON;
                end else begin
                    bright_d = bright_q + STEP8;
                end
            end
        end
    end

    assign brightness = bright_q;
    assign fade_busy  = (state_q == FADING_OUT) || (state_q == FADING_IN);

endmodule

// File: rtl/layer_color_mapper.sv
// Three-stage layer resolve / palette lookup / fade scale pixel pipeline.
// LCM_GRADIENT_EN selects a gradient background instead of palette[0].
module layer_color_mapper
    import lcm_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int PIX_BITS   = 4,
    parameter int COLOR_W    = 8,
    parameter int FADE_STEP  = 8
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic [9:0]                     DrawX,
    input  logic [9:0]                     DrawY,
    input  logic                           pix_de,
    input  logic                           frame_start,
    input  logic [NUM_LAYERS-1:0]          layer_valid,
    input  logic [NUM_LAYERS*PIX_BITS-1:0] layer_index,
    input  logic                           pal_we,
    input  logic [PIX_BITS-1:0]            pal_addr,
    input  logic [3*COLOR_W-1:0]           pal_data,
    input  logic                           fade_out_req,
    input  logic                           fade_in_req,
    output logic [COLOR_W-1:0]             VGA_R,
    output logic [COLOR_W-1:0]             VGA_G,
    output logic [COLOR_W-1:0]             VGA_B,
    output logic                           out_de,
    output logic                           fade_busy,
    output logic [7:0]                     brightness
);

    localparam int DEPTH = 1 << PIX_BITS;
    localparam int CW3   = 3 * COLOR_W;

    function automatic logic [COLOR_W-1:0] scale(
        input logic [COLOR_W-1:0] c,
        input logic [7:0]         b
    );
        logic [COLOR_W+8:0] p;
        p = (COLOR_W+9)'(c) * (COLOR_W+9)'({1'b0, b} + 9'd1);
        return p[COLOR_W+7:8];
    endfunction

    logic                unused_inputs;
    logic                hit_d;
    logic [PIX_BITS-1:0] idx_d;
    logic                s1_de_q, s1_hit_q;
    logic [PIX_BITS-1:0] s1_idx_q;
    logic [CW3-1:0]      pal_q [DEPTH];
    logic [CW3-1:0]      bg_c, s2_rgb_d, s2_rgb_q;
    logic                s2_de_q;
    logic [CW3-1:0]      out_d, out_q;
    logic                out_de_q;

    assign unused_inputs = ^{DrawY, DrawX};

    // Descending scan so the lowest-numbered opaque layer wins
    always_comb begin
        hit_d = 1'b0;
        idx_d = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_valid[i] &&
                layer_index[i*PIX_BITS +: PIX_BITS] != '0) begin
                hit_d = 1'b1;
                idx_d = layer_index[i*PIX_BITS +: PIX_BITS];
            end
        end
    end

`ifdef LCM_GRADIENT_EN
    logic [6:0] s1_x_q;

    function automatic logic [COLOR_W-1:0] grad_ch(input logic [7:0] v);
        logic [COLOR_W-1:0] r;
        r = '0;
        r[COLOR_W-1 -: 8] = v;
        return r;
    endfunction

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) s1_x_q <= '0;
        else       s1_x_q <= DrawX[9:3];
    end

    assign bg_c = {grad_ch(8'h3F), grad_ch(8'h00),
                   grad_ch(8'h7F - {1'b0, s1_x_q})};
`else
    assign bg_c = pal_q[0];
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) pal_q[i] <= '1;
        end else if (pal_we) begin
            pal_q[pal_addr] <= pal_data;
        end
    end

    assign s2_rgb_d = s1_hit_q ? pal_q[s1_idx_q] : bg_c;

    always_comb begin
        out_d = '0;
        if (s2_de_q) begin
            out_d = {scale(s2_rgb_q[CW3-1 -: COLOR_W], brightness),
                     scale(s2_rgb_q[2*COLOR_W-1 -: COLOR_W], brightness),
                     scale(s2_rgb_q[COLOR_W-1:0], brightness)};
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_de_q  <= 1'b0;
            s1_hit_q <= 1'b0;
            s1_idx_q <= '0;
            s2_de_q  <= 1'b0;
            s2_rgb_q <= '0;
            out_de_q <= 1'b0;
            out_q    <= '0;
        end else begin
            s1_de_q  <= pix_de;
            s1_hit_q <= hit_d;
            s1_idx_q <= idx_d;
            s2_de_q  <= s1_de_q;
            s2_rgb_q <= s2_rgb_d;
            out_de_q <= s2_de_q;
            out_q    <= out_d;
        end
    end

    lcm_fade_ctrl #(
        .FADE_STEP(FADE_STEP)
    ) u_fade (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .fade_out_req(fade_out_req),
        .fade_in_req (fade_in_req),
        .brightness  (brightness),
        .fade_busy   (fade_busy)
    );

    assign VGA_R  = out_q[CW3-1 -: COLOR_W];
    assign VGA_G  = out_q[2*COLOR_W-1 -: COLOR_W];
    assign VGA_B  = out_q[COLOR_W-1:0];
    assign out_de = out_de_q;

endmodule
